mod_enc_mixcolumns: RTL and testbench
=====================================

// Module: mod_enc_mixcolumns
// PURPOSE
//  Encryption MixColumns stage; sits directly downstream of mod_enc_shifter.
//  Collects four ShiftRows output rows (4 bytes each, row 0..3) into a 4x4 state buffer.
//  Emits one column per handshake, transformed by the FIPS-197 MixColumns matrix.
//  Final round (last_round=1): columns pass through untransformed.
// PARAMETERS
//  N            4   bytes per row/column; fixed at 4, kept for port sizing only
//  BYPASS_EN    1   1: last_round input honoured; 0: last_round ignored, always mix
// PORTS
//  clk         in   1       single clock, rising edge
//  resetn      in   1       asynchronous, active-low reset
//  flush       in   1       synchronous clear of partial/pending block
//  in_valid    in   1       inp holds a valid shifted row
//  in_ready    out  1       stage accepts a row this cycle
//  last_round  in   1       sampled with row 0; selects bypass for whole block
//  inp         in   [N-1:0][7:0]  row bytes; inp[c] = state byte (row, col c)
//  out_valid   out  1       outp holds a valid column
//  out_ready   in   1       downstream accepts column
//  outp        out  [N-1:0][7:0]  column bytes; outp[r] = state byte (row r, col)
//  done        out  1       1-cycle pulse on acceptance of column 3
// BEHAVIOUR
//  Clock and reset: one clock clk; reset resetn is asynchronous, active-low.
//  Reset values: state=COLLECT, row_cnt=0, col_cnt=0, outp=0, out_valid=0, done=0.
//  After reset: in_ready=1, derived combinationally from state==COLLECT.
//  Reset mid-block: buffer contents are discarded. No partial output.
//  COLLECT:
//   - in_ready=1. On in_valid: buf[row_cnt][c]=inp[c] for all c; row_cnt++.
//   - Row 0 accept: lbyp <= last_round & BYPASS_EN.
//   - Row 3 accept -> EMIT. In that same edge: outp <= f(col 0 of the completed buffer,
//     including the row-3 bytes just arriving); out_valid <= 1; col_cnt <= 0.
//  Latency: column 0 is valid on the cycle after the 4th row handshake.
//  EMIT:
//   - in_ready=0; in_valid is ignored.
//   - out_valid=1; outp is held stable while out_ready=0.
//   - On out_ready: if col_cnt<3, col_cnt++ and outp <= f(next column).
//   - If col_cnt==3: out_valid<=0, done<=1 for one cycle, row_cnt<=0, -> COLLECT.
//     in_ready returns 1 on the next cycle.
//  No overlap of collect and emit: 4 input cycles + 4 output cycles per block minimum.
//  f(col) with lbyp=0: o0=2a0^3a1^a2^a3; o1=a0^2a1^3a2^a3; o2=a0^a1^2a2^3a3;
//   o3=3a0^a1^a2^2a3.
//   - 2x = xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
//   - 3x = xtime(x) ^ x. All arithmetic is 8-bit GF(2^8); no carries.
//  f(col) with lbyp=1: identity.
//  Wrap: row_cnt and col_cnt are 2-bit counters; wrap is explicit at 3.
//  flush=1: sync return to reset values, any state. flush wins over simultaneous
//   in_valid/out_ready handshakes.
//  done never asserts without a preceding full 4-row block.
// STRUCTURE
//  Shared package aes_enc_pkg:
//   - typedef logic [7:0] byte_t; typedef byte_t [3:0] word_t.
//   - function xtime; localparam AES_POLY = 8'h1b.
//   - enum {COLLECT, EMIT} for this stage.
//  Sub-module mod_enc_mixcol_word: combinational single-column transform with bypass
//   input. Instantiated once, fed by a column mux on col_cnt.
//  Top: buffer, counters, FSM, output register.
// TESTING
//  1 Rows {db,f2,01,c6},{13,0a,01,c6},{53,22,01,c6},{45,5c,01,c6}, last_round=0,
//    out_ready=1 -> columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6; done on 4th.
//  2 Column d4,bf,5d,30 in column 0 -> outp={04,66,81,e5}.
//    Same block with last_round=1 -> outp={d4,bf,5d,30}.
//  3 Hold out_ready=0 for 5 cycles on column 1 -> outp and out_valid stable.
//    in_ready=0 and in_valid pulses ignored.
//  4 resetn low after 2 rows -> all outputs 0, in_ready=1.
//    Next 4 rows form a fresh block that matches the golden model.
//  5 flush asserted with out_ready on column 2 -> no done.
//    out_valid=0 next cycle; row_cnt=0.
//  6 Random back-to-back blocks with random valid/ready gaps -> every column matches
//    the C/Python MixColumns model; exactly one done per block.

Source files
------------

// File: rtl/aes_enc_pkg.sv
// Shared types and GF(2^8) helpers for the AES encryption datapath.
package aes_enc_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef logic [7:0] byte_t;
  typedef byte_t [3:0] word_t;

  // MixColumns stage: gather four rows, then stream out four columns
  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } mc_state_e;

  // Multiply by x in GF(2^8), reducing by the AES polynomial
  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mod_enc_mixcol_word.sv
// Single-column MixColumns transform; bypass_i passes the column through.
module mod_enc_mixcol_word
  import aes_enc_pkg::*;
(
  input  word_t col_i,
  input  logic  bypass_i,
  output word_t col_o
);

  word_t x2, x3, mix;

  for (genvar r = 0; r < 4; r++) begin : g_mul
    assign x2[r] = xtime(col_i[r]);
    assign x3[r] = x2[r] ^ col_i[r];
  end

  // Fixed circulant matrix {2,3,1,1}
  assign mix[0] = x2[0] ^ x3[1] ^ col_i[2] ^ col_i[3];
  assign mix[1] = col_i[0] ^ x2[1] ^ x3[2] ^ col_i[3];
  assign mix[2] = col_i[0] ^ col_i[1] ^ x2[2] ^ x3[3];
  assign mix[3] = x3[0] ^ col_i[1] ^ col_i[2] ^ x2[3];

  assign col_o = bypass_i ? col_i : mix;

endmodule

// File: rtl/mod_enc_mixcolumns.sv
// MixColumns stage: buffers four shifted rows, then emits four mixed columns.
module mod_enc_mixcolumns
  import aes_enc_pkg::*;
#(
  parameter int N         = 4,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               last_round,
  input  logic [N-1:0][7:0]  inp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0][7:0]  outp,
  output logic               done
);

  mc_state_e            state_q;
  logic [1:0]           row_cnt_q, col_cnt_q;
  logic                 lbyp_q;
  logic [3:0][3:0][7:0] blk_q;      // blk_q[row][col]
  word_t                outp_q;
  logic                 out_valid_q, done_q;

  logic  in_hs, out_hs;
  logic  [1:0] col_sel;
  word_t col_mux, col_mix;

  assign in_ready  = (state_q == COLLECT);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign outp      = outp_q;
  assign done      = done_q;

  // While collecting, the only column ever loaded is 0 (on the row-3 edge);
  // while emitting, the register is loaded with the next column.
  assign col_sel = (state_q == COLLECT) ? 2'd0 : col_cnt_q + 2'd1;

  // Pick the column to transform; row 3 comes straight off inp while it arrives
  always_comb begin
    col_mux = '0;
    for (int r = 0; r < 4; r++) col_mux[r] = blk_q[r][col_sel];
    if (state_q == COLLECT) col_mux[3] = inp[0];
  end

  mod_enc_mixcol_word u_mix (
    .col_i    (col_mux),
    .bypass_i (lbyp_q),
    .col_o    (col_mix)
  );

  // Collect/emit FSM with row/column counters and registered column output
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= COLLECT;
      row_cnt_q   <= 2'd0;
      col_cnt_q   <= 2'd0;
      lbyp_q      <= 1'b0;
      blk_q       <= '0;
      outp_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= COLLECT;
      row_cnt_q   <= 2'd0;
      col_cnt_q   <= 2'd0;
      lbyp_q      <= 1'b0;
      outp_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (in_hs) begin
            blk_q[row_cnt_q] <= inp;
            if (row_cnt_q == 2'd0) lbyp_q <= last_round & BYPASS_EN;
            if (row_cnt_q == 2'd3) begin
              row_cnt_q   <= 2'd0;
              col_cnt_q   <= 2'd0;
              outp_q      <= col_mix;
              out_valid_q <= 1'b1;
              state_q     <= EMIT;
            end else begin
              row_cnt_q <= row_cnt_q + 2'd1;
            end
          end
        end
        EMIT: begin
          if (out_hs) begin
            if (col_cnt_q == 2'd3) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              row_cnt_q   <= 2'd0;
              col_cnt_q   <= 2'd0;
              state_q     <= COLLECT;
            end else begin
              col_cnt_q <= col_cnt_q + 2'd1;
              outp_q    <= col_mix;
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_enc_mixcolumns.sv
// Self-checking bench for mod_enc_mixcolumns against a GF(2^8) matrix model.
module tb_mod_enc_mixcolumns;

  typedef logic [3:0][7:0] w_t;

  logic clk = 1'b0;
  logic resetn, flush, in_valid, in_ready, last_round;
  logic out_valid, out_ready, done;
  w_t   inp, outp;

  int errs = 0;
  int checks = 0;

  logic [7:0] blk [4][4];   // blk[row][col]

  always #5 clk = ~clk;

  mod_enc_mixcolumns #(.N(4), .BYPASS_EN(1'b1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .last_round (last_round),
    .inp        (inp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outp       (outp),
    .done       (done)
  );

  // Polynomial multiply followed by long-division reduction mod x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  // Output column c of the current block: matrix row r is {2,3,1,1} rotated right by r
  function automatic w_t ref_col(input int c, input bit byp);
    logic [7:0] base [4];
    logic [7:0] acc;
    w_t o;
    base = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[(k - r + 4) % 4], blk[k][c]);
      o[r] = byp ? blk[r][c] : acc;
    end
    return o;
  endfunction

  function automatic w_t mkw(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    w_t w;
    w[0] = b0; w[1] = b1; w[2] = b2; w[3] = b3;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_blk;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) blk[r][c] = 8'($urandom);
  endtask

  // Present row r; last_round only matters on row 0, so other rows get noise
  task automatic send_row(input int r, input bit lr);
    int n;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) inp[c] = blk[r][c];
    last_round = (r == 0) ? lr : 1'($urandom);
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    if (n == 50) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
    inp = w_t'($urandom);
  endtask

  task automatic send_rows(input int cnt, input bit lr, input bit gaps);
    for (int r = 0; r < cnt; r++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick;
      send_row(r, lr);
    end
  endtask

  task automatic recv_col(input string tag, input int c, input w_t exp);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin tick; n++; end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(tag, outp, exp);
    tick;
    out_ready = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, {31'd0, (c == 3)});
  endtask

  task automatic recv_block(input string tag, input bit byp, input bit gaps);
    w_t e;
    for (int c = 0; c < 4; c++) begin
      e = ref_col(c, byp);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          chk({tag, "_hold"}, outp, e);
          chk({tag, "_hold_done"}, {31'd0, done}, 32'd0);
          tick;
        end
      end
      recv_col($sformatf("%s_c%0d", tag, c), c, e);
    end
  endtask

  initial begin
    w_t e1 [4];
    w_t e;
    bit lr;

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; last_round = 1'b0;
    out_ready = 1'b0; inp = '0;
    #12;
    chk("rst_outp",      outp,                 32'd0);
    chk("rst_out_valid", {31'd0, out_valid},   32'd0);
    chk("rst_done",      {31'd0, done},        32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},    32'd1);
    tick;
    resetn = 1'b1;
    tick;

    // Known FIPS-197 block
    blk[0] = '{8'hdb, 8'hf2, 8'h01, 8'hc6};
    blk[1] = '{8'h13, 8'h0a, 8'h01, 8'hc6};
    blk[2] = '{8'h53, 8'h22, 8'h01, 8'hc6};
    blk[3] = '{8'h45, 8'h5c, 8'h01, 8'hc6};
    e1[0] = mkw(8'h8e, 8'h4d, 8'ha1, 8'hbc);
    e1[1] = mkw(8'h9f, 8'hdc, 8'h58, 8'h9d);
    e1[2] = mkw(8'h01, 8'h01, 8'h01, 8'h01);
    e1[3] = mkw(8'hc6, 8'hc6, 8'hc6, 8'hc6);
    send_rows(4, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) recv_col($sformatf("golden_c%0d", c), c, e1[c]);
    chk("golden_in_ready", {31'd0, in_ready}, 32'd1);

    // Column d4,bf,5d,30 in column 0, mixed then bypassed
    rand_blk;
    blk[0][0] = 8'hd4; blk[1][0] = 8'hbf; blk[2][0] = 8'h5d; blk[3][0] = 8'h30;
    send_rows(4, 1'b0, 1'b0);
    recv_col("d4_mix_c0", 0, mkw(8'h04, 8'h66, 8'h81, 8'he5));
    for (int c = 1; c < 4; c++) recv_col($sformatf("d4_mix_c%0d", c), c, ref_col(c, 1'b0));
    send_rows(4, 1'b1, 1'b0);
    recv_col("d4_byp_c0", 0, mkw(8'hd4, 8'hbf, 8'h5d, 8'h30));
    for (int c = 1; c < 4; c++) recv_col($sformatf("d4_byp_c%0d", c), c, ref_col(c, 1'b1));

    // Backpressure on column 1 with stray in_valid pulses
    rand_blk;
    send_rows(4, 1'b0, 1'b0);
    recv_col("stall_c0", 0, ref_col(0, 1'b0));
    e = ref_col(1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      inp = w_t'($urandom);
      chk("stall_outp",      outp,               e);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
      tick;
    end
    in_valid = 1'b0;
    for (int c = 1; c < 4; c++) recv_col($sformatf("stall_c%0d", c), c, ref_col(c, 1'b0));

    // Async reset after two rows; outp still holds the previous block's last column
    rand_blk;
    send_rows(2, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_outp",      outp,               32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_done",      {31'd0, done},      32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    tick;
    resetn = 1'b1;
    rand_blk;
    send_rows(4, 1'b0, 1'b0);
    recv_block("post_rst", 1'b0, 1'b0);

    // Flush while column 2 is being accepted
    rand_blk;
    send_rows(4, 1'b0, 1'b0);
    recv_col("flush_c0", 0, ref_col(0, 1'b0));
    recv_col("flush_c1", 1, ref_col(1, 1'b0));
    out_ready = 1'b1;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_done",      {31'd0, done},      32'd0);
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    chk("flush_outp",      outp,               32'd0);
    tick;
    chk("flush_done2",     {31'd0, done},      32'd0);
    // Flush after one collected row must restart at row 0
    rand_blk;
    send_rows(1, 1'b0, 1'b0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    rand_blk;
    send_rows(4, 1'b0, 1'b0);
    recv_block("post_flush", 1'b0, 1'b0);

    // Random blocks with random valid/ready gaps
    for (int b = 0; b < 20; b++) begin
      rand_blk;
      lr = 1'($urandom);
      send_rows(4, lr, 1'b1);
      recv_block($sformatf("rnd%0d", b), lr, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
